alu_op_sequencer: RTL and testbench

//  Control stage directly upstream of the 4-bit ALU operation blocks (and/or/xor/not/add/sub).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_result_reg.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, block count,
// FSM state encoding and the opcode-to-enable decode.
package alu_pkg;

    localparam int NUM_OPS = 6;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One-hot block enable; opcodes with no block decode to all-zero.
    function automatic logic [NUM_OPS-1:0] op_onehot(input logic [2:0] op);
        logic [NUM_OPS-1:0] dec;
        dec = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            dec[i] = (op == 3'(i));
        end
        return dec;
    endfunction

endpackage

// File: rtl/alu_result_reg.sv
// Captures the merged block result and flags at the end of EXEC and holds
// them, with out_valid, until the consumer takes them.
module alu_result_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] block_result,
    input  logic             block_carry,
    input  logic             carry_en,
    input  logic             illegal,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             illegal_op
);

    // Load on capture; only out_valid drops on handshake, data stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            illegal_op <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            result     <= block_result;
            zero_flag  <= (block_result == '0);
            carry_flag <= carry_en & block_carry;
            illegal_op <= illegal;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request sequencer in front of the ALU operation blocks: accepts one
// request, enables exactly one block for one cycle, hands the captured
// result to the consumer.
//
//   state  | meaning
//   S_IDLE | in_ready high, waiting for a request
//   S_EXEC | selected block enabled for this single cycle
//   S_DONE | result held with out_valid until out_ready
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic [NUM_OPS-1:0] op_enable,
    input  logic [WIDTH-1:0]   block_result,
    input  logic               block_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               illegal_op
);

    localparam logic [3:0] NUM_OPS_W = 4'(NUM_OPS);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] opcode_q;
    logic       accept;
    logic       in_exec;
    logic       consume;
    logic       carry_en;
    logic       illegal;

    assign accept   = (state_q == S_IDLE) && in_valid && in_ready;
    assign in_exec  = (state_q == S_EXEC);
    assign consume  = (state_q == S_DONE) && out_ready;
    assign carry_en = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);
    assign illegal  = ({1'b0, opcode_q} >= NUM_OPS_W);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> EXEC on accept, EXEC always one cycle, DONE until out_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is registered: dropped on accept, restored when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b1;
        end else if (accept) begin
            in_ready <= 1'b0;
        end else if (consume) begin
            in_ready <= 1'b1;
        end
    end

    // Operand and opcode latch; operands persist until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            opcode_q <= '0;
        end else if (accept) begin
            op_a     <= a;
            op_b     <= b;
            opcode_q <= opcode;
        end
    end

    // Block enable is high only for the EXEC cycle that follows an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_enable <= '0;
        end else if (accept) begin
            op_enable <= op_onehot(opcode);
        end else if (in_exec) begin
            op_enable <= '0;
        end
    end

    alu_result_reg #(
        .WIDTH(WIDTH)
    ) u_result_reg (
        .clk          (clk),
        .rst          (rst),
        .capture      (in_exec),
        .out_ready    (out_ready),
        .block_result (block_result),
        .block_carry  (block_carry),
        .carry_en     (carry_en),
        .illegal      (illegal),
        .out_valid    (out_valid),
        .result       (result),
        .zero_flag    (zero_flag),
        .carry_flag   (carry_flag),
        .illegal_op   (illegal_op)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the six operation blocks around the DUT
// and checks every transaction against an arithmetic reference.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [5:0] op_enable;
    logic [3:0] block_result;
    logic       block_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       zero_flag;
    logic       carry_flag;
    logic       illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(4), .NUM_OPS(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .a            (a),
        .b            (b),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_enable    (op_enable),
        .block_result (block_result),
        .block_carry  (block_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero_flag    (zero_flag),
        .carry_flag   (carry_flag),
        .illegal_op   (illegal_op)
    );

    logic [4:0] sum5;
    logic [4:0] diff5;
    assign sum5  = {1'b0, op_a} + {1'b0, op_b};
    assign diff5 = {1'b0, op_a} - {1'b0, op_b};

    // Operation blocks: each drives zero unless enabled, outputs OR-merged.
    always_comb begin
        block_result = 4'h0;
        block_carry  = 1'b0;
        if (op_enable[0]) block_result = block_result | (op_a & op_b);
        if (op_enable[1]) block_result = block_result | (op_a | op_b);
        if (op_enable[2]) block_result = block_result | (op_a ^ op_b);
        if (op_enable[3]) block_result = block_result | (~op_a);
        if (op_enable[4]) begin
            block_result = block_result | sum5[3:0];
            block_carry  = block_carry | sum5[4];
        end
        if (op_enable[5]) begin
            block_result = block_result | diff5[3:0];
            block_carry  = block_carry | diff5[4];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_op_enable"}, 32'(op_enable), 32'd0);
        check_val({tag, "_op_a"}, 32'(op_a), 32'd0);
        check_val({tag, "_op_b"}, 32'(op_b), 32'd0);
        check_val({tag, "_result"}, 32'(result), 32'd0);
        check_val({tag, "_flags"}, {29'd0, zero_flag, carry_flag, illegal_op}, 32'd0);
    endtask

    // Reference: what a request should produce, from plain integer arithmetic.
    task automatic ref_model(input int op, input int av, input int bv,
                             output int res, output int cy, output int ill, output int en);
        res = 0; cy = 0; ill = 0; en = 0;
        case (op)
            0: res = av & bv;
            1: res = av | bv;
            2: res = av ^ bv;
            3: res = 15 - av;
            4: begin res = (av + bv) % 16; cy = (av + bv > 15) ? 1 : 0; end
            5: begin res = (av - bv + 16) % 16; cy = (av < bv) ? 1 : 0; end
            default: ill = 1;
        endcase
        if (ill == 0) en = 1 << op;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) check_val({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // One full transaction with `stall` cycles of consumer backpressure.
    task automatic do_req(input string tag, input logic [2:0] op, input logic [3:0] av,
                          input logic [3:0] bv, input int stall);
        int er, ec, ei, een;
        ref_model(int'(op), int'(av), int'(bv), er, ec, ei, een);
        @(negedge clk);
        opcode    = op;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        wait_ready(tag);
        @(posedge clk); #1;
        check_val({tag, "_acc_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_acc_op_a"}, 32'(op_a), 32'(av));
        check_val({tag, "_acc_op_b"}, 32'(op_b), 32'(bv));
        check_val({tag, "_acc_op_enable"}, 32'(op_enable), 32'(een));
        check_val({tag, "_acc_out_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid  = 1'($urandom_range(0, 1));
        a         = ~av;
        b         = ~bv;
        opcode    = 3'($urandom_range(0, 7));
        out_ready = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_done_op_enable"}, 32'(op_enable), 32'd0);
        check_val({tag, "_result"}, 32'(result), 32'(er));
        check_val({tag, "_zero"}, 32'(zero_flag), (er == 0) ? 32'd1 : 32'd0);
        check_val({tag, "_carry"}, 32'(carry_flag), 32'(ec));
        check_val({tag, "_illegal"}, 32'(illegal_op), 32'(ei));
        check_val({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = 4'h3 ^ 4'(i);
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_result"}, {24'd0, zero_flag, carry_flag, illegal_op, 1'b0, result},
                      {24'd0, (er == 0) ? 1'b1 : 1'b0, 1'(ec), 1'(ei), 1'b0, 4'(er)});
            check_val({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check_val({tag, "_hold_op_a"}, 32'(op_a), 32'(av));
            check_val({tag, "_hold_op_enable"}, 32'(op_enable), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = ~av;
        @(posedge clk); #1;
        check_val({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_rel_op_a"}, 32'(op_a), 32'(av));
        check_val({tag, "_rel_result"}, 32'(result), 32'(er));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 3'd0;
        a         = 4'h0;
        b         = 4'h0;
        #23;
        rst = 1'b0;
        #1;
        check_idle_reset("reset");

        // out_ready while nothing is valid must be ignored.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_in_ready", 32'(in_ready), 32'd1);

        do_req("and", 3'd0, 4'b1100, 4'b1010, 0);
        do_req("add_carry", 3'd4, 4'hF, 4'h1, 1);
        do_req("backpressure", 3'd2, 4'h9, 4'h5, 5);
        do_req("illegal", 3'd7, 4'hA, 4'h6, 2);
        do_req("illegal6", 3'd6, 4'h0, 4'h0, 0);
        do_req("sub_borrow", 3'd5, 4'h2, 4'h7, 1);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        opcode   = 3'd1;
        a        = 4'h5;
        b        = 4'hA;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_reset("rst_done");
        @(negedge clk);
        rst = 1'b0;

        // Reset during EXEC drops the request.
        @(negedge clk);
        opcode   = 3'd4;
        a        = 4'h7;
        b        = 4'h8;
        in_valid = 1'b1;
        @(posedge clk); #2;
        check_val("rst_exec_enable_on", 32'(op_enable), 32'h10);
        rst = 1'b1;
        #1;
        check_idle_reset("rst_exec");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("rst_exec_no_valid", 32'(out_valid), 32'd0);
        end
        do_req("after_rst", 3'd3, 4'h6, 4'h0, 1);

        // Randomized traffic with idle gaps and backpressure.
        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                a        = 4'($urandom);
            end
            do_req("rand", 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                   $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
